pll_lock_sequencer: RTL

// Supervises the iCE40 SB_PLL40_CORE used for the 16->60 MHz system clock. Runs on the 16 MHz reference

---
 rtl/pll_lock_sequencer_if.sv | 38 +++
 rtl/pll_lock_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: signal bundle between the PLL lock sequencer and
// the surrounding clock/reset logic.
// Optional feature macro: PLL_FALLBACK_BYPASS_EN (adds pll_bypass).
interface pll_lock_sequencer_if #(
    parameter int unsigned MAX_RETRIES = 3
);
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    logic          locked;
    logic          restart;
    logic          pll_resetb;
    logic          sys_reset;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retry_count;
    logic [7:0]    lock_loss_count;
`ifdef PLL_FALLBACK_BYPASS_EN
    logic          pll_bypass;

    modport master (
        input  locked, restart,
        output pll_resetb, sys_reset, ready, fault, retry_count, lock_loss_count, pll_bypass
    );
    modport slave (
        output locked, restart,
        input  pll_resetb, sys_reset, ready, fault, retry_count, lock_loss_count, pll_bypass
    );
`else
    modport master (
        input  locked, restart,
        output pll_resetb, sys_reset, ready, fault, retry_count, lock_loss_count
    );
    modport slave (
        output locked, restart,
        input  pll_resetb, sys_reset, ready, fault, retry_count, lock_loss_count
    );
`endif
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: supervises the iCE40 PLL from the reference clock.
// Holds the PLL in reset, waits for lock with timeout and bounded retries,
// qualifies lock stability, then releases system reset. Any loss of lock in
// RUN re-runs the sequence. All outputs are registered from the next state.
// Optional feature macro: PLL_FALLBACK_BYPASS_EN -- in FAULT the PLL is
// bypassed and sys_reset is released after LOCK_STABLE_CYCLES.
module pll_lock_sequencer #(
    parameter int unsigned RESET_HOLD_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 16000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1600,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned CNT_W               = 16
) (
    input logic                  clock_in,
    input logic                  reset,
    pll_lock_sequencer_if.master seq
);
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_LAST   = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [7:0]       loss_q, loss_d;
    logic             sync1, locked_s;
    logic             pll_resetb_q, pll_resetb_d;
    logic             sys_reset_q, sys_reset_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
`ifdef PLL_FALLBACK_BYPASS_EN
    logic             bypass_q, bypass_d;
`endif

    // Two-flop synchroniser for the asynchronous PLL lock indication
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= seq.locked;
            locked_s <= sync1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q      <= S_RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
`ifdef PLL_FALLBACK_BYPASS_EN
            bypass_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
`ifdef PLL_FALLBACK_BYPASS_EN
            bypass_q     <= bypass_d;
`endif
        end
    end

    // Next-state, counter and output decode; restart overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (seq.restart) begin
            state_d = S_RESET_PLL;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        if (retry_q == RETRY_LAST) begin
                            state_d = S_FAULT;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = S_RESET_PLL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = cnt_q;
                    if (!locked_s) begin
                        state_d = S_RESET_PLL;
                        if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                    end
                end
                S_FAULT: begin
                    // Saturate so the bypass release condition stays true
                    cnt_d = (cnt_q == STABLE_LAST) ? cnt_q : cnt_q + 1'b1;
                end
                default: state_d = S_RESET_PLL;
            endcase
        end

        if (state_d != state_q || seq.restart) cnt_d = '0;

        pll_resetb_d = (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
        ready_d      = (state_d == S_RUN);
        fault_d      = (state_d == S_FAULT);
        sys_reset_d  = (state_d != S_RUN);
`ifdef PLL_FALLBACK_BYPASS_EN
        bypass_d     = (state_d == S_FAULT);
        if (state_q == S_FAULT && state_d == S_FAULT && cnt_q == STABLE_LAST)
            sys_reset_d = 1'b0;
`endif
    end

    assign seq.pll_resetb      = pll_resetb_q;
    assign seq.sys_reset       = sys_reset_q;
    assign seq.ready           = ready_q;
    assign seq.fault           = fault_q;
    assign seq.retry_count     = retry_q;
    assign seq.lock_loss_count = loss_q;
`ifdef PLL_FALLBACK_BYPASS_EN
    assign seq.pll_bypass      = bypass_q;
`endif

endmodule
